led_pattern_divider: RTL and testbench

Parametrised LED driver for board-level bring-up and status display. A programmable prescaler divides CLK down to a single-cycle step tick, and a pattern engine advances an N-bit LED vector once per tick in one of four run-time-selectable modes: binary count, rotating light, bouncing light or blink. It sits directly between the board clock/reset and the LED pins, replacing fixed tap-off-a-counter dividers.

---
 rtl/led_pattern_divider.sv | 103 ++++++++++
 tb/tb_led_pattern_divider.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/led_pattern_divider.sv
// LED pattern driver: programmable prescaler plus four-mode pattern engine.
// Binary count, rotating light, bouncing light and blink, one step per tick.
module led_pattern_divider #(
  parameter int DIV_W = 24,
  parameter int N_LED = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic [DIV_W-1:0] DIV_MAX,
  input  logic [1:0]       MODE,
  output logic [N_LED-1:0] LED,
  output logic             TICK
);

  localparam logic [1:0] M_BIN = 2'd0;
  localparam logic [1:0] M_ROT = 2'd1;
  localparam logic [1:0] M_BNC = 2'd2;
  localparam logic [1:0] M_BLK = 2'd3;

  localparam logic [N_LED-1:0] ONE =
    {{(N_LED-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] cnt, cnt_d;
  logic [1:0]       mode_q;
  logic             dir, dir_d;
  logic [N_LED-1:0] led_d;
  logic             tick_d;
  logic [N_LED-1:0] init_pat, step_pat;
  logic             step_dir;
  logic             mode_chg;

  assign mode_chg = (MODE != mode_q);

  // state register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt    <= '0;
      mode_q <= M_BIN;
      dir    <= 1'b0;
      LED    <= '0;
      TICK   <= 1'b0;
    end else begin
      cnt    <= cnt_d;
      mode_q <= MODE;
      dir    <= dir_d;
      LED    <= led_d;
      TICK   <= tick_d;
    end
  end

  always_comb begin
    init_pat = '0;
    unique case (MODE)
      M_ROT,
      M_BNC:   init_pat = ONE;
      default: init_pat = '0;
    endcase
  end

  // bounce flips direction on the same edge it lands on an end bit
  always_comb begin
    step_pat = LED;
    step_dir = dir;
    unique case (mode_q)
      M_BIN: step_pat = LED + ONE;
      M_ROT: step_pat = {LED[N_LED-2:0], LED[N_LED-1]};
      M_BNC: begin
        if (!dir) begin
          step_pat = LED << 1;
          step_dir = step_pat[N_LED-1];
        end else begin
          step_pat = LED >> 1;
          step_dir = ~step_pat[0];
        end
      end
      M_BLK: step_pat = ~LED;
    endcase
  end

  // next-state selection; mode change outranks enable and tick
  always_comb begin
    cnt_d  = cnt;
    dir_d  = dir;
    led_d  = LED;
    tick_d = 1'b0;
    if (mode_chg) begin
      cnt_d = '0;
      dir_d = 1'b0;
      led_d = init_pat;
    end else if (!EN) begin
      cnt_d = cnt;
    end else if (cnt >= DIV_MAX) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      led_d  = step_pat;
      dir_d  = step_dir;
    end else begin
      cnt_d = cnt + {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_led_pattern_divider.sv
// Directed bench for led_pattern_divider (N_LED=8, DIV_W=24).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_led_pattern_divider;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        EN;
  logic [23:0] DIV_MAX;
  logic [1:0]  MODE;
  logic [7:0]  LED;
  logic        TICK;

  int checks = 0;
  int errors = 0;

  led_pattern_divider #(.DIV_W(24), .N_LED(8)) dut (
    .CLK(CLK), .RESET(RESET), .EN(EN),
    .DIV_MAX(DIV_MAX), .MODE(MODE),
    .LED(LED), .TICK(TICK)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic expect_out(input string tag,
                            input logic [7:0] l,
                            input logic t);
    chk({tag, " led"}, {24'd0, LED}, {24'd0, l});
    chk({tag, " tick"}, {31'd0, TICK}, {31'd0, t});
  endtask

  logic [7:0] bseq [16];
  logic [7:0] e;

  initial begin
    bseq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
             8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04,
             8'h02, 8'h01, 8'h02, 8'h04};
    RESET   = 1'b0;
    EN      = 1'b1;
    MODE    = 2'd0;
    DIV_MAX = 24'd3;
    #2;
    expect_out("reset", 8'h00, 1'b0);
    @(negedge CLK);
    RESET = 1'b1;

    // first step on the 4th edge, then every 4 cycles
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out("pre_first", 8'h00, 1'b0);
    end
    step();
    expect_out("first_step", 8'h01, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out("hold_01", 8'h01, 1'b0);
    end
    step();
    expect_out("second_step", 8'h02, 1'b1);

    // DIV_MAX=0: step every cycle, wrap FF->00
    DIV_MAX = 24'd0;
    e = 8'h02;
    for (int i = 0; i < 256; i++) begin
      step();
      e = e + 8'h01;
      expect_out("bin_div0", e, 1'b1);
    end

    // bounce, each value held two cycles
    MODE    = 2'd2;
    DIV_MAX = 24'd1;
    step();
    expect_out("bnc_init", 8'h01, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step();
      chk("bnc_hold_tick", {31'd0, TICK}, 32'd0);
      step();
      expect_out("bnc_step", bseq[i], 1'b1);
    end

    // rotate up to 80 then wrap to 01
    MODE = 2'd1;
    step();
    expect_out("rot_init", 8'h01, 1'b0);
    e = 8'h01;
    for (int i = 0; i < 8; i++) begin
      step();
      step();
      e = {e[6:0], e[7]};
      expect_out("rot_step", e, 1'b1);
    end
    chk("rot_wrapped", {24'd0, LED}, 32'h01);

    // mode change on the edge where cnt==DIV_MAX
    step();
    MODE = 2'd3;
    step();
    expect_out("blk_collide", 8'h00, 1'b0);
    step();
    expect_out("blk_wait", 8'h00, 1'b0);
    step();
    expect_out("blk_first", 8'hFF, 1'b1);

    // freeze at cnt=5 for 20 cycles
    DIV_MAX = 24'd9;
    for (int i = 0; i < 5; i++) step();
    EN = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      expect_out("frozen", 8'hFF, 1'b0);
    end
    EN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_out("resume_wait", 8'hFF, 1'b0);
    end
    step();
    expect_out("resume_step", 8'h00, 1'b1);

    // shrink DIV_MAX below cnt=7
    for (int i = 0; i < 7; i++) step();
    expect_out("cnt7", 8'h00, 1'b0);
    DIV_MAX = 24'd2;
    step();
    expect_out("shrink_step", 8'hFF, 1'b1);
    step();
    expect_out("shrink_w1", 8'hFF, 1'b0);
    step();
    expect_out("shrink_w2", 8'hFF, 1'b0);
    step();
    expect_out("shrink_next", 8'h00, 1'b1);

    // async reset while bouncing right at 10
    MODE    = 2'd2;
    DIV_MAX = 24'd0;
    step();
    expect_out("bnc2_init", 8'h01, 1'b0);
    for (int i = 0; i < 10; i++) step();
    expect_out("bnc2_at10", 8'h10, 1'b1);
    #2;
    RESET = 1'b0;
    #1;
    expect_out("async_rst", 8'h00, 1'b0);
    #1;
    RESET = 1'b1;
    step();
    expect_out("post_rst", 8'h01, 1'b0);
    step();
    expect_out("post_rst_left", 8'h02, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
